regfile_mp_scoreboard: RTL

//   Parametrised multi-port integer register file for the pipelined RV32I core.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_scoreboard.sv | 67 ++++++
 rtl/regfile_mp_scoreboard.sv | 90 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and defaults for the multi-port register file.
// Provides the address-width helper used by every rf_* module.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int rf_clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2)
      r++;
    return r;
  endfunction

  localparam int AW_DEF = rf_clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write tracking: one busy bit per register.
// Issue sets, retire clears, issue wins a same-cycle collision.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS     = NREGS_DEF,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  parameter int AW        = rf_clog2(NREGS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_READ*AW-1:0]  rd_addr,
  output logic [NUM_READ-1:0]     rd_busy,
  input  logic [NUM_WRITE-1:0]    wr_en,
  input  logic [NUM_WRITE*AW-1:0] wr_addr,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  output logic                    busy_any
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < NUM_WRITE; j++)
      if (wr_en[j])
        wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
  end

  // Clear first, then set: a new producer outranks the retiring one.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (iss_en)
      busy_d[iss_addr] = 1'b1;
    if (ZERO_REG != 0)
      busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy_any = |busy_q;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          b;
    assign ra = rd_addr[i*AW +: AW];
    always_comb begin
      b = busy_q[ra];
      if (BYPASS != 0 && wr_hit[ra])
        b = 1'b0;
      if (ZERO_REG != 0 && ra == '0)
        b = 1'b0;
    end
    assign rd_busy[i] = b;
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with busy scoreboard,
// write-to-read bypass and highest-port-wins write arbitration.
module regfile_mp_scoreboard
  import rf_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREGS     = NREGS_DEF,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  localparam int AW       = rf_clog2(NREGS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*XLEN-1:0]  rd_data,
  output logic [NUM_READ-1:0]       rd_busy,
  input  logic [NUM_WRITE-1:0]      wr_en,
  input  logic [NUM_WRITE*AW-1:0]   wr_addr,
  input  logic [NUM_WRITE*XLEN-1:0] wr_data,
  input  logic                      iss_en,
  input  logic [AW-1:0]             iss_addr,
  output logic                      busy_any
);

  logic [XLEN-1:0] mem [NREGS];

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    logic            we;
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] q;

    // Later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
      we = 1'b0;
      wd = '0;
      for (int j = 0; j < NUM_WRITE; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) begin
          we = 1'b1;
          wd = wr_data[j*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clock) begin
      if (!reset)
        q <= '0;
      else if (we && !(ZERO_REG != 0 && r == 0))
        q <= wd;
    end

    assign mem[r] = q;
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] d;
    assign ra = rd_addr[i*AW +: AW];
    always_comb begin
      d = mem[ra];
      if (BYPASS != 0)
        for (int j = 0; j < NUM_WRITE; j++)
          if (wr_en[j] && wr_addr[j*AW +: AW] == ra)
            d = wr_data[j*XLEN +: XLEN];
      if (ZERO_REG != 0 && ra == '0)
        d = '0;
    end
    assign rd_data[i*XLEN +: XLEN] = d;
  end

  rf_scoreboard #(
    .NREGS     (NREGS),
    .NUM_READ  (NUM_READ),
    .NUM_WRITE (NUM_WRITE),
    .BYPASS    (BYPASS),
    .ZERO_REG  (ZERO_REG),
    .AW        (AW)
  ) u_sb (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_any (busy_any)
  );

endmodule
